median9_stream: RTL



---
 rtl/median9_stream.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/median9_stream.sv
// -----------------------------------------------------------------------------
// median9_stream
//
// Streaming 3x3-window rank filter. Samples shift into a 9-deep window
// (w[0] newest, w[8] oldest). Each accepted sample that leaves the window full
// launches one result through a registered compare-exchange network:
//   launch reg -> stage 1 (row sorts) -> stage 2 (column reductions)
//   -> stage 3 (rank select into the output register)
// An accepted sample at edge k appears on out_valid at edge k+3.
//
// Handshake: in_valid is a one-way strobe with no backpressure. in_data and
// mode are taken on every rising edge where in_valid=1 and flush=0.
// out_valid is a single-cycle pulse per result, and the consumer must take it
// in that cycle.
//
// Parameters
//   WIDTH   sample width in bits (2..32)
//   SIGNED  1 = two's-complement ordering, 0 = unsigned ordering
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear of window fill and all in-flight results
//   in_valid     sample strobe
//   in_data      input sample
//   mode         00 median, 01 min, 10 max, 11 centre (w4); taken with in_valid
//   out_valid    one-cycle result strobe
//   out_data     result
//   out_mode     mode that produced out_data
//   window_full  fill count has reached 9
// -----------------------------------------------------------------------------
module median9_stream #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_mode,
    output logic             window_full
);

    localparam logic [1:0] MODE_MED = 2'b00;
    localparam logic [1:0] MODE_MIN = 2'b01;
    localparam logic [1:0] MODE_MAX = 2'b10;

    // ---------------------------------------------------------------------
    // Ordering primitives
    // ---------------------------------------------------------------------
    function automatic logic lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED) return ($signed(a) < $signed(b));
        return (a < b);
    endfunction

    // Ties return the first argument, so equal values never reorder.
    function automatic logic [WIDTH-1:0] min2(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return lt(b, a) ? b : a;
    endfunction

    function automatic logic [WIDTH-1:0] max2(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return lt(b, a) ? a : b;
    endfunction

    function automatic logic [WIDTH-1:0] med3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // Three compare-exchanges; returns {hi, mid, lo}. Swaps only on strict
    // less-than, which keeps duplicates stable.
    function automatic logic [3*WIDTH-1:0] sort3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] x0, x1, x2, t;
        x0 = a;
        x1 = b;
        x2 = c;
        if (lt(x1, x0)) begin t = x0; x0 = x1; x1 = t; end
        if (lt(x2, x1)) begin t = x1; x1 = x2; x2 = t; end
        if (lt(x1, x0)) begin t = x0; x0 = x1; x1 = t; end
        return {x2, x1, x0};
    endfunction

    // ---------------------------------------------------------------------
    // Window and fill tracking
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] win_q [9];
    logic [WIDTH-1:0] win_d [9];
    logic [3:0]       fill_q, fill_d;
    logic             accept;
    logic             launch_d, launch_q;
    logic [1:0]       launch_mode_q;

    // flush has priority: a sample presented with flush is dropped.
    assign accept = in_valid & ~flush;

    always_comb begin
        win_d = win_q;
        if (accept) begin
            win_d[0] = in_data;
            for (int i = 1; i < 9; i++) win_d[i] = win_q[i-1];
        end
    end

    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = 4'd0;
        end else if (accept && (fill_q != 4'd9)) begin
            fill_d = fill_q + 4'd1;
        end
    end

    // The window is full after this shift when 8 or more samples were
    // already present before it.
    assign launch_d    = accept && (fill_q >= 4'd8);
    assign window_full = (fill_q == 4'd9);

    // ---------------------------------------------------------------------
    // Stage 1: sort each row of the window registered at the launch edge
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] s1_lo_d  [3];
    logic [WIDTH-1:0] s1_mid_d [3];
    logic [WIDTH-1:0] s1_hi_d  [3];
    logic [WIDTH-1:0] s1_lo_q  [3];
    logic [WIDTH-1:0] s1_mid_q [3];
    logic [WIDTH-1:0] s1_hi_q  [3];
    logic [WIDTH-1:0] s1_ctr_q;
    logic [1:0]       s1_mode_q;
    logic             s1_valid_q;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            {s1_hi_d[r], s1_mid_d[r], s1_lo_d[r]} = sort3(win_q[3*r], win_q[3*r+1], win_q[3*r+2]);
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: column reductions of the row-sorted matrix. The global median
    // is the median of (max of row minima, median of row medians, min of
    // row maxima).
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] s2_maxlo_d, s2_medmid_d, s2_minhi_d, s2_min_d, s2_max_d;
    logic [WIDTH-1:0] s2_maxlo_q, s2_medmid_q, s2_minhi_q, s2_min_q, s2_max_q;
    logic [WIDTH-1:0] s2_ctr_q;
    logic [1:0]       s2_mode_q;
    logic             s2_valid_q;

    always_comb begin
        s2_maxlo_d  = max2(max2(s1_lo_q[0], s1_lo_q[1]), s1_lo_q[2]);
        s2_medmid_d = med3(s1_mid_q[0], s1_mid_q[1], s1_mid_q[2]);
        s2_minhi_d  = min2(min2(s1_hi_q[0], s1_hi_q[1]), s1_hi_q[2]);
        s2_min_d    = min2(min2(s1_lo_q[0], s1_lo_q[1]), s1_lo_q[2]);
        s2_max_d    = max2(max2(s1_hi_q[0], s1_hi_q[1]), s1_hi_q[2]);
    end

    // ---------------------------------------------------------------------
    // Stage 3: final median and rank select
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] out_data_d, out_data_q;
    logic [1:0]       out_mode_q;
    logic             out_valid_q;

    always_comb begin
        case (s2_mode_q)
            MODE_MED: out_data_d = med3(s2_maxlo_q, s2_medmid_q, s2_minhi_q);
            MODE_MIN: out_data_d = s2_min_q;
            MODE_MAX: out_data_d = s2_max_q;
            default:  out_data_d = s2_ctr_q;
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers. flush clears every valid bit in the pipe, which
    // kills the results due on the next three edges.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
            fill_q        <= 4'd0;
            launch_q      <= 1'b0;
            launch_mode_q <= 2'b00;
            for (int r = 0; r < 3; r++) begin
                s1_lo_q[r]  <= '0;
                s1_mid_q[r] <= '0;
                s1_hi_q[r]  <= '0;
            end
            s1_ctr_q      <= '0;
            s1_mode_q     <= 2'b00;
            s1_valid_q    <= 1'b0;
            s2_maxlo_q    <= '0;
            s2_medmid_q   <= '0;
            s2_minhi_q    <= '0;
            s2_min_q      <= '0;
            s2_max_q      <= '0;
            s2_ctr_q      <= '0;
            s2_mode_q     <= 2'b00;
            s2_valid_q    <= 1'b0;
            out_data_q    <= '0;
            out_mode_q    <= 2'b00;
            out_valid_q   <= 1'b0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;

            launch_q      <= launch_d;
            launch_mode_q <= launch_d ? mode : launch_mode_q;

            s1_lo_q    <= s1_lo_d;
            s1_mid_q   <= s1_mid_d;
            s1_hi_q    <= s1_hi_d;
            s1_ctr_q   <= win_q[4];
            s1_mode_q  <= launch_mode_q;
            s1_valid_q <= launch_q & ~flush;

            s2_maxlo_q  <= s2_maxlo_d;
            s2_medmid_q <= s2_medmid_d;
            s2_minhi_q  <= s2_minhi_d;
            s2_min_q    <= s2_min_d;
            s2_max_q    <= s2_max_d;
            s2_ctr_q    <= s1_ctr_q;
            s2_mode_q   <= s1_mode_q;
            s2_valid_q  <= s1_valid_q & ~flush;

            // out_data holds the last result between strobes.
            if (s2_valid_q) begin
                out_data_q <= out_data_d;
                out_mode_q <= s2_mode_q;
            end
            out_valid_q <= s2_valid_q & ~flush;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;

endmodule
